// File: rtl/mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mm_sequencer
// Purpose  : Op-stream sequencer for page loads, size configuration and
//            matmul streaming into an NxN systolic multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mm_sequencer #(
    parameter int N         = 8,
    parameter int DW        = 32,
    parameter int PAGE_BITS = 2,
    parameter int CELL_BITS = 6,
    parameter int LINE_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [31:0]          operation,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic [DW-1:0]        wr_data,
    output logic                 w_we,
    output logic                 x_we,
    output logic [PAGE_BITS-1:0] w_wsel,
    output logic [PAGE_BITS-1:0] x_wsel,
    output logic [PAGE_BITS-1:0] w_rsel,
    output logic [PAGE_BITS-1:0] x_rsel,
    output logic                 shift_en,
    output logic                 w_switch,
    output logic                 x_switch,
    output logic                 x_bulk_we,
    output logic                 relu,
    output logic                 transpose,
    input  logic                 clear_out,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int                    c_DRAIN_W    = $clog2(2 * N) + 1;
    localparam logic [c_DRAIN_W-1:0]  c_DRAIN_LAST = c_DRAIN_W'(2 * N - 1);
    localparam logic [3:0]            c_OP_NOP     = 4'd0;
    localparam logic [3:0]            c_OP_MATMUL  = 4'd1;
    localparam logic [3:0]            c_OP_LOAD    = 4'd2;
    localparam logic [3:0]            c_OP_CONFIG  = 4'd3;
    localparam logic [CELL_BITS-1:0]  c_CELLS_RST  = CELL_BITS'(15);
    localparam logic [LINE_BITS-1:0]  c_LINES_RST  = LINE_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_done_set;
    logic                   w_err_set;
    logic                   r_done;
    logic                   r_err;
    logic                   r_y_valid;

    logic [CELL_BITS-1:0]   r_w_cells;
    logic [LINE_BITS-1:0]   r_w_lines;
    logic [LINE_BITS-1:0]   r_x_lines;

    logic [CELL_BITS-1:0]   r_wc;
    logic [LINE_BITS-1:0]   r_wl;
    logic [LINE_BITS-1:0]   r_xl;
    logic [c_DRAIN_W-1:0]   r_drain_cnt;
    logic [3:0]             r_beat_cnt;
    logic [3:0]             r_beat_last;
    logic                   r_dest_is_w;
    logic                   r_y_is_w;
    logic                   r_relu;
    logic                   r_transpose;
    logic [PAGE_BITS-1:0]   r_w_wsel;
    logic [PAGE_BITS-1:0]   r_x_wsel;
    logic [PAGE_BITS-1:0]   r_w_rsel;
    logic [PAGE_BITS-1:0]   r_x_rsel;

    logic [3:0]             w_opcode;
    logic [3:0]             w_chunk_a;
    logic [3:0]             w_chunk_b;
    logic [3:0]             w_chunk_c;
    logic [3:0]             w_chunk_d;
    logic                   w_accept;
    logic                   w_beat;
    logic                   w_last_beat;
    logic                   w_stream_step;
    logic                   w_wsw_int;
    logic                   w_xsw_int;
    logic                   w_last_stream;
    logic                   w_drain_last;
    logic                   w_unused;

    assign w_opcode  = operation[3:0];
    assign w_chunk_a = operation[7:4];
    assign w_chunk_b = operation[11:8];
    assign w_chunk_c = operation[15:12];
    assign w_chunk_d = operation[19:16];
    assign w_unused  = ^{operation, in_data};

    assign w_accept      = op_valid && op_ready && enable;
    assign w_beat        = (r_state == S_LOAD) && in_valid && enable;
    assign w_last_beat   = w_beat && (r_beat_cnt == r_beat_last);
    assign w_stream_step = (r_state == S_STREAM) && enable;
    assign w_wsw_int     = w_stream_step && (r_wc == r_w_cells);
    assign w_xsw_int     = w_wsw_int && (r_wl == r_w_lines);
    assign w_last_stream = w_xsw_int && (r_xl == r_x_lines);
    assign w_drain_last  = (r_state == S_DRAIN) && enable && (r_drain_cnt == c_DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (enable) begin
            r_state <= w_state_next;
            r_done  <= w_done_set;
            r_err   <= w_err_set;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_opcode)
                        c_OP_NOP:    ;
                        c_OP_MATMUL: w_state_next = S_STREAM;
                        c_OP_LOAD:   w_state_next = S_LOAD;
                        c_OP_CONFIG: w_done_set   = 1'b1;
                        default:     w_err_set    = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                if (w_last_beat) begin
                    w_state_next = S_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            S_STREAM: begin
                if (w_last_stream) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_last) begin
                    w_state_next = S_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Op latching, configuration and the stream/drain/beat counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_cells   <= c_CELLS_RST;
            r_w_lines   <= c_LINES_RST;
            r_x_lines   <= c_LINES_RST;
            r_wc        <= '0;
            r_wl        <= '0;
            r_xl        <= '0;
            r_drain_cnt <= '0;
            r_beat_cnt  <= '0;
            r_beat_last <= '0;
            r_dest_is_w <= 1'b0;
            r_y_is_w    <= 1'b0;
            r_relu      <= 1'b0;
            r_transpose <= 1'b0;
            r_w_wsel    <= '0;
            r_x_wsel    <= '0;
            r_w_rsel    <= '0;
            r_x_rsel    <= '0;
            r_y_valid   <= 1'b0;
        end else if (enable) begin
            r_y_valid <= clear_out;
            if (w_accept) begin
                case (w_opcode)
                    c_OP_MATMUL: begin
                        r_wc        <= '0;
                        r_wl        <= '0;
                        r_xl        <= '0;
                        r_drain_cnt <= '0;
                        r_x_rsel    <= w_chunk_a[3] ? '0 : w_chunk_a[PAGE_BITS-1:0];
                        r_w_rsel    <= w_chunk_b[3] ? w_chunk_b[PAGE_BITS-1:0] : '0;
                        r_y_is_w    <= w_chunk_c[3];
                        if (!w_chunk_c[3]) begin
                            r_x_wsel <= w_chunk_c[PAGE_BITS-1:0];
                        end
                        r_relu      <= w_chunk_d[1];
                        r_transpose <= w_chunk_d[0];
                    end
                    c_OP_LOAD: begin
                        r_beat_cnt  <= '0;
                        r_beat_last <= w_chunk_b;
                        r_dest_is_w <= w_chunk_a[3];
                        if (w_chunk_a[3]) begin
                            r_w_wsel <= w_chunk_a[PAGE_BITS-1:0];
                        end else begin
                            r_x_wsel <= w_chunk_a[PAGE_BITS-1:0];
                        end
                    end
                    c_OP_CONFIG: begin
                        r_w_cells <= in_data[CELL_BITS-1:0];
                        r_w_lines <= in_data[CELL_BITS +: LINE_BITS];
                        r_x_lines <= in_data[CELL_BITS + LINE_BITS +: LINE_BITS];
                    end
                    default: ;
                endcase
            end
            if (w_stream_step) begin
                r_wc <= w_wsw_int ? '0 : r_wc + 1'b1;
                if (w_wsw_int) begin
                    r_wl <= w_xsw_int ? '0 : r_wl + 1'b1;
                end
                if (w_xsw_int) begin
                    r_xl <= r_xl + 1'b1;
                end
            end
            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign op_ready  = (r_state == S_IDLE);
    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign wr_data   = in_data;
    assign w_we      = w_beat && r_dest_is_w;
    assign x_we      = w_beat && !r_dest_is_w;
    assign w_wsel    = r_w_wsel;
    assign x_wsel    = r_x_wsel;
    assign w_rsel    = r_w_rsel;
    assign x_rsel    = r_x_rsel;
    assign shift_en  = w_stream_step;
    // Transposed operands reverse which memory advances per line vs per page
    assign w_switch  = r_transpose ? w_xsw_int : w_wsw_int;
    assign x_switch  = r_transpose ? w_wsw_int : w_xsw_int;
    assign x_bulk_we = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && !r_y_is_w;
    assign relu      = r_relu;
    assign transpose = r_transpose;
    assign done      = r_done && enable;
    assign err       = r_err && enable;
    assign y_valid   = r_y_valid && enable;

endmodule
`default_nettype wire

// File: tb/tb_mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_sequencer
// Purpose  : Self-checking bench for mm_sequencer against a schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_sequencer;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int PB = 2;

    logic          clk = 1'b0;
    logic          reset, enable, op_valid, in_valid, clear_out;
    logic [31:0]   operation;
    logic [DW-1:0] in_data;
    logic          op_ready, in_ready, w_we, x_we, shift_en, w_switch, x_switch;
    logic          x_bulk_we, relu, transpose, y_valid, busy, done, err;
    logic [DW-1:0] wr_data;
    logic [PB-1:0] w_wsel, x_wsel, w_rsel, x_rsel;

    int n_checks = 0;
    int n_fail   = 0;
    logic prev_clear = 1'b0, prev_en = 1'b0, prev_rst = 1'b1;

    mm_sequencer #(.N(N), .DW(DW), .PAGE_BITS(PB), .CELL_BITS(6), .LINE_BITS(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .op_valid(op_valid), .op_ready(op_ready),
        .operation(operation), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_data(wr_data), .w_we(w_we), .x_we(x_we), .w_wsel(w_wsel), .x_wsel(x_wsel),
        .w_rsel(w_rsel), .x_rsel(x_rsel), .shift_en(shift_en), .w_switch(w_switch),
        .x_switch(x_switch), .x_bulk_we(x_bulk_we), .relu(relu), .transpose(transpose),
        .clear_out(clear_out), .y_valid(y_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prev_clear <= clear_out;
        prev_en    <= enable;
        prev_rst   <= reset;
    end

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b1; op_valid = 1'b0; in_valid = 1'b0;
        in_data = '0; operation = '0; clear_out = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({op_ready, in_ready, busy, done, err, y_valid, shift_en, w_switch, x_switch,
             x_bulk_we, relu, transpose, w_we, x_we} !== 14'b1000_0000_0000_00) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=%b", {op_ready, in_ready, busy, done, err, y_valid,
                     shift_en, w_switch, x_switch, x_bulk_we, relu, transpose, w_we, x_we},
                     14'b1000_0000_0000_00);
        end
        n_checks++;
        if ({w_wsel, x_wsel, w_rsel, x_rsel, wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_sels got=%h exp=0", {w_wsel, x_wsel, w_rsel, x_rsel, wr_data});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one MATMUL; the expected schedule comes from the product of the sizes.
    task automatic do_matmul(input int cells, input int lines, input int xlines, input bit tr,
                             input logic [3:0] ypg, input bit hold, input int fz_at, input int fz_len);
        logic [3:0] xa, wb;
        logic       rl, e_s, e_w, e_x, e_wo, e_xo;
        int         len, t_done, k;
        xa = 4'($urandom); wb = 4'($urandom); rl = 1'($urandom);
        len    = (cells + 1) * (lines + 1) * (xlines + 1);
        t_done = len + 2 * N + 1 + fz_len;
        k = 0;
        @(negedge clk);
        enable = 1'b1; op_valid = 1'b1;
        operation = {12'h0, 2'b00, rl, tr, ypg, wb, xa, 4'd1};
        #1;
        n_checks++;
        if (op_ready !== 1'b1) begin n_fail++; $display("FAIL mm_accept op_ready got=%b exp=1", op_ready); end
        for (int t = 1; t <= t_done + 1; t++) begin
            @(negedge clk);
            if (!hold) op_valid = 1'b0;
            enable    = !(fz_len > 0 && t > fz_at && t <= fz_at + fz_len);
            clear_out = 1'($urandom);
            #1;
            if (t == t_done + 1) begin
                n_checks++;
                if (busy !== hold || shift_en !== hold) begin
                    n_fail++;
                    $display("FAIL mm_after_done busy=%b shift=%b exp=%b", busy, shift_en, hold);
                end
            end else begin
                e_s = enable && (k < len);
                if (e_s) k++;
                e_w  = e_s && (k % (cells + 1) == 0);
                e_x  = e_s && (k % ((cells + 1) * (lines + 1)) == 0);
                e_wo = tr ? e_x : e_w;
                e_xo = tr ? e_w : e_x;
                n_checks++;
                if (shift_en !== e_s) begin
                    n_fail++; $display("FAIL mm_shift t=%0d got=%b exp=%b", t, shift_en, e_s);
                end
                n_checks++;
                if ({w_switch, x_switch} !== {e_wo, e_xo}) begin
                    n_fail++;
                    $display("FAIL mm_switch t=%0d got=%b%b exp=%b%b", t, w_switch, x_switch, e_wo, e_xo);
                end
                n_checks++;
                if ({busy, done, err, op_ready} !== {(t < t_done), (t == t_done), 1'b0, (t == t_done)}) begin
                    n_fail++;
                    $display("FAIL mm_status t=%0d got busy/done/err/rdy=%b exp=%b", t,
                             {busy, done, err, op_ready}, {(t < t_done), (t == t_done), 1'b0, (t == t_done)});
                end
                n_checks++;
                if (x_bulk_we !== ((t < t_done) && !ypg[3])) begin
                    n_fail++; $display("FAIL mm_bulk t=%0d got=%b exp=%b", t, x_bulk_we, (t < t_done) && !ypg[3]);
                end
                if (!enable) begin
                    n_checks++;
                    if (y_valid !== 1'b0) begin n_fail++; $display("FAIL yv_frozen t=%0d got=%b exp=0", t, y_valid); end
                end else if (prev_en && !prev_rst) begin
                    n_checks++;
                    if (y_valid !== prev_clear) begin
                        n_fail++; $display("FAIL yv_track t=%0d got=%b exp=%b", t, y_valid, prev_clear);
                    end
                end
            end
            if (t == 1) begin
                n_checks++;
                if ({x_rsel, w_rsel, relu, transpose} !==
                    {(xa[3] ? 2'b00 : xa[1:0]), (wb[3] ? wb[1:0] : 2'b00), rl, tr}) begin
                    n_fail++;
                    $display("FAIL mm_latch got=%b exp=%b", {x_rsel, w_rsel, relu, transpose},
                             {(xa[3] ? 2'b00 : xa[1:0]), (wb[3] ? wb[1:0] : 2'b00), rl, tr});
                end
            end
        end
        op_valid = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic do_config(input int c, input int l, input int x);
        @(negedge clk);
        enable = 1'b1; op_valid = 1'b1; operation = 32'd3;
        in_data = $urandom;
        in_data[11:0] = {3'(x), 3'(l), 6'(c)};
        #1;
        n_checks++;
        if (op_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_accept got=%b exp=1", op_ready); end
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        n_checks++;
        if ({done, busy, err} !== 3'b100) begin
            n_fail++; $display("FAIL cfg_done got done/busy/err=%b exp=100", {done, busy, err});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL cfg_pulse got=%b exp=0", done); end
    endtask

    task automatic do_load(input logic [3:0] pg, input logic [3:0] b, input logic [15:0] pat, input bit use_pat);
        int beats;
        bit fin;
        beats = 0; fin = 1'b0;
        @(negedge clk);
        enable = 1'b1; op_valid = 1'b1; in_valid = 1'b0;
        operation = {20'h0, b, pg, 4'd2};
        #1;
        n_checks++;
        if (op_ready !== 1'b1) begin n_fail++; $display("FAIL ld_accept got=%b exp=1", op_ready); end
        for (int t = 1; t <= 64 && !fin; t++) begin
            @(negedge clk);
            op_valid  = 1'b0;
            in_valid  = use_pat ? pat[(t - 1) % 16] : 1'($urandom);
            in_data   = $urandom;
            clear_out = 1'($urandom);
            #1;
            n_checks++;
            if ({in_ready, busy, done} !== 3'b110) begin
                n_fail++; $display("FAIL ld_state t=%0d got rdy/busy/done=%b exp=110", t, {in_ready, busy, done});
            end
            n_checks++;
            if ({w_we, x_we} !== {in_valid && pg[3], in_valid && !pg[3]} || wr_data !== in_data) begin
                n_fail++;
                $display("FAIL ld_we t=%0d got=%b%b data=%h exp=%b%b data=%h", t, w_we, x_we, wr_data,
                         in_valid && pg[3], in_valid && !pg[3], in_data);
            end
            if (in_valid) beats++;
            if (beats == int'(b) + 1) fin = 1'b1;
        end
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL ld_timeout got beats=%0d exp=%0d", beats, int'(b) + 1); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({done, busy, in_ready, w_we, x_we} !== 5'b10000) begin
            n_fail++; $display("FAIL ld_done got=%b exp=10000", {done, busy, in_ready, w_we, x_we});
        end
        n_checks++;
        if ((pg[3] ? w_wsel : x_wsel) !== pg[1:0]) begin
            n_fail++; $display("FAIL ld_wsel got=%0d exp=%0d", pg[3] ? w_wsel : x_wsel, pg[1:0]);
        end
    endtask

    task automatic test_unsupported();
        logic [3:0] opc;
        for (int i = 0; i < 5; i++) begin
            opc = (i == 0) ? 4'd7 : (i == 4) ? 4'd0 : 4'($urandom_range(4, 15));
            @(negedge clk);
            op_valid = 1'b1; operation = {$urandom, opc} >> 0;
            operation[3:0] = opc;
            #1;
            @(negedge clk);
            op_valid = 1'b0;
            #1;
            n_checks++;
            if ({err, done, busy} !== {(opc != 4'd0), 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL unsup op=%0d got err/done/busy=%b exp=%b", opc, {err, done, busy},
                                   {(opc != 4'd0), 1'b0, 1'b0});
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (err !== 1'b0) begin n_fail++; $display("FAIL unsup_pulse got=%b exp=0", err); end
        end
    endtask

    task automatic test_reset_abort();
        do_config(20, 0, 0);
        @(negedge clk);
        op_valid = 1'b1; operation = {12'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'd1};
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            op_valid = 1'b0;
            if (t == 10) reset = 1'b1;
            #1;
            n_checks++;
            if (shift_en !== 1'b1) begin n_fail++; $display("FAIL abort_stream t=%0d got=%b exp=1", t, shift_en); end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({busy, shift_en, done, op_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL abort_idle got=%b exp=0001", {busy, shift_en, done, op_ready});
        end
        reset = 1'b0;
        // abort a LOAD after two beats
        @(negedge clk);
        op_valid = 1'b1; operation = {20'h0, 4'd5, 4'h2, 4'd2};
        @(negedge clk);
        op_valid = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, in_ready, w_we, x_we, done} !== 5'b00000) begin
            n_fail++; $display("FAIL abort_load got=%b exp=00000", {busy, in_ready, w_we, x_we, done});
        end
        in_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL abort_nodone t=%0d got=%b exp=0", t, done); end
        end
        do_matmul(15, 1, 1, 1'b0, 4'h1, 1'b0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; op_valid = 1'b0; in_valid = 1'b0;
        in_data = '0; operation = '0; clear_out = 1'b0;
        test_reset();
        do_matmul(15, 1, 1, 1'b0, 4'($urandom) & 4'h7, 1'b0, 0, 0);
        do_config(1, 0, 0);
        do_matmul(1, 0, 0, 1'b0, 4'h2, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            int c, l, x;
            c = $urandom_range(0, 6); l = $urandom_range(0, 2); x = $urandom_range(0, 2);
            do_config(c, l, x);
            do_matmul(c, l, x, 1'($urandom), 4'($urandom), 1'b0, 0, 0);
        end
        do_load(4'h9, 4'd3, 16'h001D, 1'b1);
        for (int i = 0; i < 3; i++) begin
            do_load(4'($urandom), 4'($urandom_range(0, 5)), 16'h0, 1'b0);
        end
        test_reset();
        do_matmul(15, 1, 1, 1'b1, 4'h8, 1'b0, 0, 0);
        do_matmul(15, 1, 1, 1'b0, 4'h3, 1'b1, 20, 5);
        test_reset();
        test_unsupported();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
